outport_sched: RTL and testbench
================================

Name: outport_sched

Overview:
- Per-output-port packet scheduler for the 5-input router.
- Arbitrates decoded requests from the five input channels with round-robin fairness and a multicast/absorb priority class.
- Locks the output to one input from head flit to tail flit (wormhole), and gates every flit transfer on a downstream credit counter.
- Drives the crossbar mux select and the per-input grant lines for one output port.

Parameters:
- PORTID, 0, output port index; informational only, no logic depends on it.
- CREDITS, 4, downstream buffer depth in flits; also the credit counter reset value (legal range 1..7).
- CRDW, 3, credit counter width; must satisfy CREDITS < 2**CRDW.

Ports:
- clk  in  1  clock
- rst_  in  1  reset; synchronous, active-low, asserted when rst_ == `Enable_ (0)
- req  in  `PORT_P1  per-input request; input i holds a flit destined to this port
- pri  in  `PORT_P1  per-input multicast/absorb flag; qualifies req[i]
- tail  in  `PORT_P1  per-input flag: the flit presented on input i is a tail (or single-flit packet)
- crd_ret  in  1  one credit returned by downstream this cycle
- grt  out  `PORT_P1  one-hot or zero grant; flit on granted input transfers this cycle (combinational)
- sel  out  `PORT_P1  registered copy of grt; crossbar mux select for the pipelined data stage
- fwd  out  1  a flit transfers this cycle; equals |grt
- crd_cnt  out  CRDW  current credit count (registered)
- busy  out  1  packet lock active (state == LOCK)
- crd_err  out  1  sticky credit overflow flag

Behaviour:
- Reset, synchronous, evaluated at posedge clk: state=IDLE, lock=0, rr_ptr=0, sel=0, crd_cnt=CREDITS, crd_err=0. grt, fwd and busy are therefore 0 while reset is asserted.
- Reset mid-packet abandons the lock immediately, with no tail required.
- Eligible set: elig = req & pri if |(req & pri), else elig = req. Priority inputs always pre-empt in IDLE only; they never break an active lock.
- Round-robin pick: the first set bit of elig searching rr_ptr, rr_ptr+1, ... modulo 5.
- can_send = (crd_cnt != 0).
- IDLE:
  - If |elig and can_send: grt = onehot(winner), fwd = 1.
  - If tail[winner]: stay IDLE, rr_ptr <= (winner+1) mod 5.
  - Else: state <= LOCK, lock <= onehot(winner).
  - If |elig and !can_send: grt = 0; no state change; rr_ptr unchanged.
- LOCK:
  - grt = lock only if req[lock] and can_send. pri and other requests are ignored.
  - If req[lock] drops: grt = 0 and the lock is held (bubble).
  - On a granted flit with tail[lock]=1: state <= IDLE, rr_ptr <= (index(lock)+1) mod 5, lock <= 0.
- Latency: grant is same-cycle combinational; sel follows grt by exactly one cycle (sel <= grt every cycle).
- Credit counter: crd_cnt <= crd_cnt - fwd + crd_ret.
  - Simultaneous fwd and crd_ret: count unchanged.
  - fwd is impossible at 0 because it is gated by can_send.
  - crd_ret at crd_cnt == CREDITS with fwd=0: hold at CREDITS and set crd_err. crd_err clears only on reset.
- Flit accounting: at most one flit per cycle; flits transferred never exceed credits available.

Decomposition:
- Shared define.h:
  - Existing: `PORT, `PORT_P1, `Enable_.
  - Add: `OS_IDLE, `OS_LOCK state encodings and a default `CRDW.
- One combinational sub-module, rr_pick5: inputs elig[4:0], ptr[2:0]; outputs onehot[4:0] and idx[2:0].
- FSM, lock register, credit counter and sel register live in outport_sched.

Test Plan:
- Single-flit packets: req=5'b10110, tail=all 1s, pri=0, CREDITS=4, crd_ret each cycle -> grants in order 1, 2, 4, 1, 2, 4; sel is the same sequence delayed one cycle.
- 3-flit packet on input 3 (tail on 3rd flit), then req[0] raised in cycle 2 -> grt=01000 for three consecutive cycles, busy=1 in cycles 2-3, grt=00001 in cycle 4, rr_ptr=4 after the tail.
- Priority: req=11111, pri=00100 in IDLE with rr_ptr=0 -> grt=00100. pri asserted on input 0 during a lock on input 3 -> lock unbroken until the tail.
- Credit exhaustion: CREDITS=4, no crd_ret, continuous 8-flit packet -> exactly 4 fwd pulses, crd_cnt=0, grt=0; a single crd_ret -> one more flit next cycle. Simultaneous fwd and crd_ret keeps crd_cnt constant.
- Overflow: crd_ret=1 at crd_cnt=4 with no traffic -> crd_cnt stays 4, crd_err=1 and sticky.
- Reset mid-lock: rst_=0 during the 2nd flit of a 3-flit packet -> next cycle busy=0, grt=0, sel=0, crd_cnt=4, rr_ptr=0.

Source files
------------

// File: rtl/outport_sched_pkg.sv
// Shared types and helpers for the per-output-port scheduler: FSM encoding,
// port count and round-robin pointer arithmetic.
package outport_sched_pkg;

    localparam int NPORT = 5;

    typedef enum logic {
        OS_IDLE = 1'b0,
        OS_LOCK = 1'b1
    } os_state_t;

    // Pointer advance modulo the five input channels.
    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        return (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [4:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/outport_sched_if.sv
// Request/grant/credit bundle between the router input side (master) and one
// output-port scheduler (slave).
interface outport_sched_if #(
    parameter int CRDW = 3
) ();

    logic [4:0]      req;
    logic [4:0]      pri;
    logic [4:0]      tail;
    logic            crd_ret;
    logic [4:0]      grt;
    logic [4:0]      sel;
    logic            fwd;
    logic [CRDW-1:0] crd_cnt;
    logic            busy;
    logic            crd_err;

    modport master (
        output req, pri, tail, crd_ret,
        input  grt, sel, fwd, crd_cnt, busy, crd_err
    );

    modport slave (
        input  req, pri, tail, crd_ret,
        output grt, sel, fwd, crd_cnt, busy, crd_err
    );

endinterface

// File: rtl/outport_sched_rr_pick5.sv
// Five-way round-robin picker: first set bit of elig starting at ptr, wrapping
// modulo 5. Purely combinational.
module rr_pick5 (
    input  logic [4:0] elig,
    input  logic [2:0] ptr,
    output logic [4:0] onehot,
    output logic [2:0] idx
);

    logic       found;
    logic [3:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 0; k < 5; k++) begin
            pos = 4'(ptr) + 4'(k);
            if (pos >= 4'd5) pos = pos - 4'd5;
            if (!found && elig[pos[2:0]]) begin
                found            = 1'b1;
                onehot[pos[2:0]] = 1'b1;
                idx              = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/outport_sched.sv
// Output-port scheduler: round-robin with priority class in IDLE, wormhole lock
// from head to tail, every flit gated on the downstream credit counter.
module outport_sched
    import outport_sched_pkg::*;
#(
    parameter int PORTID  = 0,
    parameter int CREDITS = 4,
    parameter int CRDW    = 3
) (
    input  logic           clk,
    input  logic           rst_,
    outport_sched_if.slave bus
);

    if (PORTID < 0 || PORTID >= NPORT) begin : g_bad_portid
        $error("outport_sched: PORTID out of range");
    end
    if (CREDITS < 1 || CREDITS >= (1 << CRDW)) begin : g_bad_credits
        $error("outport_sched: CREDITS must be in 1..2**CRDW-1");
    end

    os_state_t       state;
    logic [4:0]      lock;
    logic [2:0]      rr_ptr;
    logic [4:0]      sel_p1;
    logic [CRDW-1:0] crd_cnt;
    logic            crd_err;

    logic [4:0] prio, elig, win_oh, grt_p0;
    logic [2:0] win_idx;
    logic       can_send, fwd_p0;

    assign prio     = bus.req & bus.pri;
    assign elig     = (|prio) ? prio : bus.req;
    assign can_send = (crd_cnt != '0);

    rr_pick5 u_pick (
        .elig   (elig),
        .ptr    (rr_ptr),
        .onehot (win_oh),
        .idx    (win_idx)
    );

    // Grant is suppressed while reset is asserted so a half-sent packet cannot
    // leak a flit in the reset cycle.
    always_comb begin
        grt_p0 = '0;
        if (rst_ && can_send) begin
            if (state == OS_IDLE)          grt_p0 = win_oh;
            else if (|(bus.req & lock))    grt_p0 = lock;
        end
    end

    assign fwd_p0 = |grt_p0;

    // ---- p0 -> p1: FSM, lock, round-robin pointer, mux select, credits ----
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state   <= OS_IDLE;
            lock    <= '0;
            rr_ptr  <= '0;
            sel_p1  <= '0;
            crd_cnt <= CRDW'(CREDITS);
            crd_err <= 1'b0;
        end else begin
            sel_p1 <= grt_p0;
            case (state)
                OS_IDLE: begin
                    if (fwd_p0) begin
                        if (|(bus.tail & win_oh)) begin
                            rr_ptr <= next_ptr(win_idx);
                        end else begin
                            state <= OS_LOCK;
                            lock  <= win_oh;
                        end
                    end
                end
                OS_LOCK: begin
                    if (fwd_p0 && |(bus.tail & lock)) begin
                        state  <= OS_IDLE;
                        lock   <= '0;
                        rr_ptr <= next_ptr(onehot_idx(lock));
                    end
                end
                default: state <= OS_IDLE;
            endcase

            if (fwd_p0 && !bus.crd_ret) begin
                crd_cnt <= crd_cnt - CRDW'(1);
            end else if (!fwd_p0 && bus.crd_ret) begin
                // A return with the buffer already fully credited is a
                // downstream protocol error: hold the count, flag it.
                if (crd_cnt == CRDW'(CREDITS)) crd_err <= 1'b1;
                else                           crd_cnt <= crd_cnt + CRDW'(1);
            end
        end
    end

    assign bus.grt     = grt_p0;
    assign bus.fwd     = fwd_p0;
    assign bus.sel     = sel_p1;
    assign bus.crd_cnt = crd_cnt;
    assign bus.busy    = (state == OS_LOCK);
    assign bus.crd_err = crd_err;

endmodule

// File: tb/tb_outport_sched.sv
// Self-checking bench for outport_sched: directed scenarios followed by random
// traffic, all compared against a packet-level reference model.
module tb_outport_sched;

    localparam int CREDITS = 4;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    outport_sched_if #(.CRDW(3)) bus ();

    outport_sched #(.PORTID(0), .CREDITS(CREDITS), .CRDW(3)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner of the output (-1 = free), next round-robin start,
    // credits available, sticky error, and the grant seen last cycle.
    int         m_owner = -1;
    int         m_rr    = 0;
    int         m_cred  = CREDITS;
    bit         m_err   = 1'b0;
    logic [4:0] m_sel   = '0;
    bit         known   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [4:0] r, input logic [4:0] p, input logic rn);
        logic [4:0] e;
        if (!rn || m_cred == 0) return -1;
        if (m_owner >= 0) return r[m_owner] ? m_owner : -1;
        e = ((r & p) != 5'd0) ? (r & p) : r;
        for (int k = 0; k < 5; k++) begin
            if (e[(m_rr + k) % 5]) return (m_rr + k) % 5;
        end
        return -1;
    endfunction

    task automatic cyc(input logic [4:0] r, input logic [4:0] p, input logic [4:0] t,
                       input logic cr, input logic rn);
        int         g;
        logic [4:0] eg;
        @(negedge clk);
        bus.req     = r;
        bus.pri     = p;
        bus.tail    = t;
        bus.crd_ret = cr;
        rst_        = rn;
        g  = pick(r, p, rn);
        eg = (g >= 0) ? 5'(1 << g) : 5'd0;
        #1;
        if (known) begin
            chk("grt",     bus.grt,     eg);
            chk("fwd",     bus.fwd,     (g >= 0));
            chk("busy",    bus.busy,    (m_owner >= 0));
            chk("sel",     bus.sel,     m_sel);
            chk("crd_cnt", bus.crd_cnt, m_cred);
            chk("crd_err", bus.crd_err, m_err);
        end
        if (!rn) begin
            m_owner = -1; m_rr = 0; m_cred = CREDITS; m_err = 1'b0; m_sel = '0;
        end else begin
            m_sel = eg;
            if (g >= 0) begin
                if (t[g]) begin
                    m_owner = -1;
                    m_rr    = (g + 1) % 5;
                end else begin
                    m_owner = g;
                end
            end
            if (g >= 0 && !cr)       m_cred--;
            else if (g < 0 && cr) begin
                if (m_cred == CREDITS) m_err = 1'b1;
                else                   m_cred++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] exp1 [6];
        logic [4:0] exp2 [4];
        int         nfwd;

        bus.req = '0; bus.pri = '0; bus.tail = '0; bus.crd_ret = 1'b0;
        exp1 = '{5'b00010, 5'b00100, 5'b10000, 5'b00010, 5'b00100, 5'b10000};
        exp2 = '{5'b01000, 5'b01000, 5'b01000, 5'b00001};

        cyc(5'b0, 5'b0, 5'b0, 1'b0, 1'b0);
        cyc(5'b0, 5'b0, 5'b0, 1'b0, 1'b0);
        known = 1'b1;

        // Single-flit packets rotate 1, 2, 4.
        for (int i = 0; i < 6; i++) begin
            cyc(5'b10110, 5'b0, 5'b11111, 1'b1, 1'b1);
            chk("rr_order", bus.grt, exp1[i]);
        end

        // Three-flit packet on input 3; input 0 (even with pri) waits for the tail.
        cyc(5'b01000, 5'b00000, 5'b00000, 1'b1, 1'b1);
        chk("lock_g0", bus.grt, exp2[0]);
        cyc(5'b01001, 5'b00001, 5'b00000, 1'b1, 1'b1);
        chk("lock_g1", bus.grt, exp2[1]);
        cyc(5'b01001, 5'b00001, 5'b01000, 1'b1, 1'b1);
        chk("lock_g2", bus.grt, exp2[2]);
        chk("lock_busy", bus.busy, 1'b1);
        cyc(5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b1);
        chk("after_tail", bus.grt, exp2[3]);

        // Priority class wins in IDLE regardless of pointer.
        cyc(5'b0, 5'b0, 5'b0, 1'b0, 1'b0);
        cyc(5'b11111, 5'b00100, 5'b11111, 1'b1, 1'b1);
        chk("pri_win", bus.grt, 5'b00100);

        // Credit exhaustion on a long packet from input 1.
        nfwd = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(5'b00010, 5'b0, 5'b0, 1'b0, 1'b1);
            if (bus.fwd) nfwd++;
        end
        chk("exh_fwds", nfwd, 4);
        chk("exh_cnt", bus.crd_cnt, 0);
        cyc(5'b00010, 5'b0, 5'b0, 1'b1, 1'b1);
        chk("no_crd_grt", bus.grt, 5'b00000);
        cyc(5'b00010, 5'b0, 5'b0, 1'b0, 1'b1);
        chk("one_more", bus.grt, 5'b00010);
        cyc(5'b00010, 5'b0, 5'b0, 1'b1, 1'b1);
        cyc(5'b00010, 5'b0, 5'b0, 1'b1, 1'b1);
        chk("fwd_ret_fwd", bus.fwd, 1'b1);
        cyc(5'b00010, 5'b0, 5'b00010, 1'b1, 1'b1);
        chk("fwd_ret_hold", bus.crd_cnt, 1);
        chk("fwd_ret_tail", bus.fwd, 1'b1);
        for (int i = 0; i < 3; i++) cyc(5'b0, 5'b0, 5'b0, 1'b1, 1'b1);

        // Credit overflow is held and sticky.
        cyc(5'b0, 5'b0, 5'b0, 1'b1, 1'b1);
        cyc(5'b0, 5'b0, 5'b0, 1'b0, 1'b1);
        chk("ovf_err", bus.crd_err, 1'b1);
        chk("ovf_cnt", bus.crd_cnt, 4);
        for (int i = 0; i < 3; i++) cyc(5'b0, 5'b0, 5'b0, 1'b0, 1'b1);
        chk("err_sticky", bus.crd_err, 1'b1);

        // Reset in the middle of a locked packet.
        cyc(5'b01000, 5'b0, 5'b0, 1'b1, 1'b1);
        chk("pre_rst_g", bus.grt, 5'b01000);
        cyc(5'b01000, 5'b0, 5'b0, 1'b1, 1'b0);
        chk("rst_grt", bus.grt, 5'b00000);
        cyc(5'b11111, 5'b0, 5'b11111, 1'b1, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_sel", bus.sel, 5'b00000);
        chk("rst_cnt", bus.crd_cnt, 4);
        chk("rst_err", bus.crd_err, 1'b0);
        chk("rst_ptr", bus.grt, 5'b00001);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [4:0] r, p, t;
            logic       cr, rn;
            r  = 5'($urandom);
            p  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            t  = 5'($urandom);
            cr = ($urandom_range(0, 1) == 0);
            rn = ($urandom_range(0, 63) != 0);
            cyc(r, p, t, cr, rn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
